// File: rtl/onehot_scan_decoder_if.sv
// Select/decode bundle for onehot_scan_decoder: select request in, one-hot index out.
interface onehot_scan_decoder_if #(
  parameter int N = 3
);
  logic              en;
  logic              mode;
  logic              s_valid;
  logic [N-1:0]      s;
  logic              s_ready;
  logic [(1<<N)-1:0] y;
  logic              y_valid;
  logic [N-1:0]      idx;

  modport master (output en, mode, s_valid, s, input s_ready, y, y_valid, idx);
  modport slave  (input en, mode, s_valid, s, output s_ready, y, y_valid, idx);
endinterface

// File: rtl/onehot_scan_decoder.sv
// Registered one-hot decoder with direct-select and timed auto-scan modes.
// Each output bit is its own lane so y can only ever be zero or one-hot.
module onehot_scan_decoder_lane #(
  parameter int N    = 3,
  parameter int LANE = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [N-1:0] idx_nxt,
  output logic         y_bit
);
  localparam logic [N-1:0] LANE_IDX = N'(LANE);

  always_ff @(posedge clk) begin
    if (rst) y_bit <= 1'b0;
    else     y_bit <= en && (idx_nxt == LANE_IDX);
  end
endmodule

module onehot_scan_decoder #(
  parameter int N     = 3,
  parameter int DWELL = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  onehot_scan_decoder_if.slave   bus
);
  localparam int NUM_LANES = 1 << N;
  localparam int CW        = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);

  // State records the mode seen at the last enabled edge; entering scan restarts the dwell.
  typedef enum logic {ST_DIRECT, ST_SCAN} state_t;

  state_t                 state, state_nxt;
  logic [N-1:0]           idx_q, idx_nxt;
  logic [CW-1:0]          cnt_q, cnt_nxt, cnt_eff;
  logic [NUM_LANES-1:0]   y_q;
  logic                   vld_q;
  logic                   xfer;

  assign bus.s_ready = bus.en & ~bus.mode & ~rst;
  assign xfer        = bus.s_valid & bus.s_ready;

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx_q;
    cnt_nxt   = cnt_q;
    cnt_eff   = cnt_q;
    case (state)
      ST_DIRECT: begin
        cnt_eff = '0;
        if (bus.mode) state_nxt = ST_SCAN;
      end
      ST_SCAN: begin
        if (!bus.mode) state_nxt = ST_DIRECT;
      end
      default: state_nxt = ST_DIRECT;
    endcase
    if (bus.mode) begin
      if (cnt_eff == CNT_LAST) begin
        idx_nxt = idx_q + 1'b1;
        cnt_nxt = '0;
      end else begin
        cnt_nxt = cnt_eff + 1'b1;
      end
    end else if (xfer) begin
      idx_nxt = bus.s;
    end
  end

  // Disabled edges freeze index, dwell and mode history; only the outputs go idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_DIRECT;
      idx_q <= '0;
      cnt_q <= '0;
      vld_q <= 1'b0;
    end else if (bus.en) begin
      state <= state_nxt;
      idx_q <= idx_nxt;
      cnt_q <= cnt_nxt;
      vld_q <= 1'b1;
    end else begin
      vld_q <= 1'b0;
    end
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    onehot_scan_decoder_lane #(.N(N), .LANE(g)) u_lane (
      .clk     (clk),
      .rst     (rst),
      .en      (bus.en),
      .idx_nxt (idx_nxt),
      .y_bit   (y_q[g])
    );
  end

  assign bus.y       = y_q;
  assign bus.y_valid = vld_q;
  assign bus.idx     = idx_q;
endmodule

// File: tb/tb_onehot_scan_decoder.sv
// Scoreboarded bench: N=3/DWELL=4 and N=4/DWELL=1 instances driven with directed vectors.
module tb_onehot_scan_decoder;
  logic clk = 1'b0;
  logic rst_a, rst_b;
  int   n_pass = 0, n_total = 0;

  always #5 clk = ~clk;

  onehot_scan_decoder_if #(.N(3)) bus_a ();
  onehot_scan_decoder_if #(.N(4)) bus_b ();

  onehot_scan_decoder #(.N(3), .DWELL(4)) dut_a (.clk(clk), .rst(rst_a), .bus(bus_a));
  onehot_scan_decoder #(.N(4), .DWELL(1)) dut_b (.clk(clk), .rst(rst_b), .bus(bus_b));

  typedef struct {
    logic [15:0] y;
    logic        v;
    logic [3:0]  idx;
  } exp_t;

  exp_t  qa[$], qb[$];
  string na[$], nb[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else n_pass++;
  endtask

  task automatic cyc_a(input logic r, e, m, v, input logic [2:0] sv, input logic er,
                       input logic [7:0] ey, input logic ev, input logic [2:0] ei,
                       input string nm, input bit glitch = 1'b0);
    @(negedge clk);
    rst_a = r; bus_a.en = e; bus_a.mode = m; bus_a.s_valid = v; bus_a.s = sv;
    qa.push_back('{y: 16'(ey), v: ev, idx: 4'(ei)});
    na.push_back(nm);
    if (glitch) begin
      #1 rst_a = 1'b1;
      #1 chk({nm, "_glitch_rdy"}, 32'(bus_a.s_ready), 32'd0);
      #1 rst_a = 1'b0;
    end
    #1 chk({nm, "_rdy"}, 32'(bus_a.s_ready), 32'(er));
  endtask

  task automatic cyc_b(input logic r, e, m, v, input logic [3:0] sv, input logic er,
                       input logic [15:0] ey, input logic ev, input logic [3:0] ei,
                       input string nm);
    @(negedge clk);
    rst_b = r; bus_b.en = e; bus_b.mode = m; bus_b.s_valid = v; bus_b.s = sv;
    qb.push_back('{y: ey, v: ev, idx: ei});
    nb.push_back(nm);
    #1 chk({nm, "_rdy"}, 32'(bus_b.s_ready), 32'(er));
  endtask

  initial begin : mon_a
    exp_t  e;
    string nm;
    forever begin
      @(posedge clk);
      #1;
      if (qa.size() > 0) begin
        e = qa.pop_front(); nm = na.pop_front();
        chk({nm, "_y"},   32'(bus_a.y),       32'(e.y));
        chk({nm, "_vld"}, 32'(bus_a.y_valid), 32'(e.v));
        chk({nm, "_idx"}, 32'(bus_a.idx),     32'(e.idx));
      end
    end
  end

  initial begin : mon_b
    exp_t  e;
    string nm;
    forever begin
      @(posedge clk);
      #1;
      if (qb.size() > 0) begin
        e = qb.pop_front(); nm = nb.pop_front();
        chk({nm, "_y"},   32'(bus_b.y),       32'(e.y));
        chk({nm, "_vld"}, 32'(bus_b.y_valid), 32'(e.v));
        chk({nm, "_idx"}, 32'(bus_b.idx),     32'(e.idx));
      end
    end
  end

  task automatic seq_a();
    //     r  e  m  v  s  rdy  y     v  idx
    cyc_a(1, 1, 0, 1, 5, 0, 8'h00, 0, 0, "rst_over_xfer");
    cyc_a(1, 0, 0, 0, 0, 0, 8'h00, 0, 0, "reset");
    cyc_a(0, 1, 0, 1, 5, 1, 8'h20, 1, 5, "xfer5");
    for (int k = 0; k < 2; k++) cyc_a(0, 1, 0, 0, 2, 1, 8'h20, 1, 5, "hold5");
    cyc_a(0, 1, 0, 1, 1, 1, 8'h02, 1, 1, "b2b1");
    cyc_a(0, 1, 0, 1, 6, 1, 8'h40, 1, 6, "xfer6");
    for (int k = 0; k < 3; k++) cyc_a(0, 1, 1, 0, 0, 0, 8'h40, 1, 6, "scan6");
    cyc_a(0, 1, 1, 0, 0, 0, 8'h80, 1, 7, "adv7");
    for (int k = 0; k < 3; k++) cyc_a(0, 1, 1, 1, 2, 0, 8'h80, 1, 7, "scan7_drop");
    cyc_a(0, 1, 1, 1, 2, 0, 8'h01, 1, 0, "wrap0");
    for (int k = 0; k < 3; k++) cyc_a(0, 1, 1, 0, 0, 0, 8'h01, 1, 0, "scan0");
    for (int k = 0; k < 4; k++) cyc_a(0, 1, 1, 0, 0, 0, 8'h02, 1, 1, "scan1");
    for (int k = 0; k < 4; k++) cyc_a(0, 1, 1, 0, 0, 0, 8'h04, 1, 2, "scan2");
    for (int k = 0; k < 2; k++) cyc_a(0, 1, 1, 0, 0, 0, 8'h08, 1, 3, "scan3");
    for (int k = 0; k < 3; k++) cyc_a(0, 0, 1, 0, 0, 0, 8'h00, 0, 3, "gap");
    for (int k = 0; k < 2; k++) cyc_a(0, 1, 1, 0, 0, 0, 8'h08, 1, 3, "resume3");
    cyc_a(0, 1, 1, 0, 0, 0, 8'h10, 1, 4, "adv4");
    for (int k = 0; k < 2; k++) cyc_a(0, 1, 1, 0, 0, 0, 8'h10, 1, 4, "scan4");
    for (int k = 0; k < 2; k++) cyc_a(0, 1, 0, 0, 0, 1, 8'h10, 1, 4, "direct_hold");
    cyc_a(0, 1, 0, 1, 7, 1, 8'h80, 1, 7, "xfer7", 1'b1);
    for (int k = 0; k < 2; k++) cyc_a(0, 1, 1, 0, 0, 0, 8'h80, 1, 7, "rescan7");
    cyc_a(1, 1, 1, 0, 0, 0, 8'h00, 0, 0, "rst_midscan");
    for (int k = 0; k < 2; k++) cyc_a(0, 1, 1, 0, 0, 0, 8'h01, 1, 0, "post_rst");
  endtask

  task automatic seq_b();
    cyc_b(1, 0, 0, 0,  0, 0, 16'h0000, 0,  0, "b_reset");
    cyc_b(0, 1, 0, 1, 15, 1, 16'h8000, 1, 15, "b_xfer15");
    cyc_b(0, 1, 1, 0,  0, 0, 16'h0001, 1,  0, "b_wrap");
    cyc_b(0, 1, 1, 1,  9, 0, 16'h0002, 1,  1, "b_adv1");
    cyc_b(0, 0, 1, 0,  0, 0, 16'h0000, 0,  1, "b_gap");
    cyc_b(0, 1, 1, 0,  0, 0, 16'h0004, 1,  2, "b_adv2");
    cyc_b(0, 1, 0, 1,  0, 1, 16'h0001, 1,  0, "b_xfer0");
  endtask

  initial begin
    int wait_cyc;
    rst_a = 1'b1; rst_b = 1'b1;
    bus_a.en = 1'b0; bus_a.mode = 1'b0; bus_a.s_valid = 1'b0; bus_a.s = '0;
    bus_b.en = 1'b0; bus_b.mode = 1'b0; bus_b.s_valid = 1'b0; bus_b.s = '0;
    fork
      seq_a();
      seq_b();
    join
    wait_cyc = 0;
    while ((qa.size() > 0 || qb.size() > 0) && wait_cyc < 20) begin
      @(posedge clk);
      #2;
      wait_cyc++;
    end
    if (qa.size() > 0 || qb.size() > 0) begin
      n_total++;
      $display("FAIL drain: %0d expected responses left, required 0", qa.size() + qb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
